reorder_buffer_tagged: RTL and testbench

//  Parametrised in-order read-response buffer between an AXI-style AR/R slave and master.

---
 rtl/reorder_buffer_tagged_if.sv | 38 +++
 rtl/reorder_buffer_tagged.sv | 76 +++++++
 tb/tb_reorder_buffer_tagged.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_tagged_if.sv
// AR/R channel bundle between the upstream slave port, the reorder buffer and the downstream master port.
// The slave modport is the buffer's view; the master modport is the surrounding system's view.
interface reorder_buffer_tagged_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 16
);
  localparam int TW = $clog2(DEPTH);

  logic [ID_WIDTH-1:0]   s_arid_i;
  logic                  s_arvalid_i;
  logic                  s_arready_o;
  logic [DATA_WIDTH-1:0] s_rdata_o;
  logic [ID_WIDTH-1:0]   s_rid_o;
  logic                  s_rvalid_o;
  logic                  s_rready_i;
  logic [TW-1:0]         m_arid_o;
  logic                  m_arvalid_o;
  logic                  m_arready_i;
  logic [DATA_WIDTH-1:0] m_rdata_i;
  logic [TW-1:0]         m_rid_i;
  logic                  m_rvalid_i;
  logic                  m_rready_o;
  logic [TW:0]           count_o;
  logic                  err_unexp_o;

  modport slave (
    input  s_arid_i, s_arvalid_i, s_rready_i, m_arready_i, m_rdata_i, m_rid_i, m_rvalid_i,
    output s_arready_o, s_rdata_o, s_rid_o, s_rvalid_o, m_arid_o, m_arvalid_o, m_rready_o,
           count_o, err_unexp_o
  );

  modport master (
    output s_arid_i, s_arvalid_i, s_rready_i, m_arready_i, m_rdata_i, m_rid_i, m_rvalid_i,
    input  s_arready_o, s_rdata_o, s_rid_o, s_rvalid_o, m_arid_o, m_arvalid_o, m_rready_o,
           count_o, err_unexp_o
  );
endinterface

// File: rtl/reorder_buffer_tagged.sv
// Tagged read reorder buffer: each accepted AR is given a slot tag, out-of-order R beats land
// in their slot, and responses retire upstream strictly in AR-acceptance order.
module reorder_buffer_tagged #(
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  reorder_buffer_tagged_if.slave bus
);
  localparam int TW = $clog2(DEPTH);

  logic [TW:0]           wr_ptr_reg, rd_ptr_reg;
  logic [DEPTH-1:0]      pend_reg, pend_next;
  logic [DEPTH-1:0]      done_reg, done_next;
  logic                  err_reg;
  logic [ID_WIDTH-1:0]   id_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [TW-1:0] wr_tag, rd_tag;
  logic          empty, full, ar_hs, rs_hs, r_ok, s_rvalid;

  assign wr_tag = wr_ptr_reg[TW-1:0];
  assign rd_tag = rd_ptr_reg[TW-1:0];
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_tag == rd_tag) && (wr_ptr_reg[TW] != rd_ptr_reg[TW]);

  assign ar_hs    = bus.s_arvalid_i & bus.m_arready_i & ~full;
  assign s_rvalid = ~empty & done_reg[rd_tag];
  assign rs_hs    = s_rvalid & bus.s_rready_i;
  // A beat is only accepted for an allocated slot still waiting for data; anything else is dropped.
  assign r_ok     = bus.m_rvalid_i & pend_reg[bus.m_rid_i] & ~done_reg[bus.m_rid_i];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      localparam logic [TW-1:0] SLOT = TW'(gi);
      assign pend_next[gi] = (ar_hs && wr_tag == SLOT) ? 1'b1 :
                             (rs_hs && rd_tag == SLOT) ? 1'b0 : pend_reg[gi];
      assign done_next[gi] = (rs_hs && rd_tag == SLOT)          ? 1'b0 :
                             (r_ok && bus.m_rid_i == SLOT)      ? 1'b1 : done_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      pend_reg   <= '0;
      done_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      if (ar_hs) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rs_hs) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      pend_reg <= pend_next;
      done_reg <= done_next;
      err_reg  <= bus.m_rvalid_i & ~r_ok;
    end
  end

  // Payload storage carries no reset; validity is tracked entirely by pend/done.
  always_ff @(posedge clk) begin
    if (ar_hs) id_mem[wr_tag] <= bus.s_arid_i;
    if (r_ok)  data_mem[bus.m_rid_i] <= bus.m_rdata_i;
  end

  assign bus.m_arvalid_o = bus.s_arvalid_i & ~full;
  assign bus.s_arready_o = bus.m_arready_i & ~full;
  assign bus.m_arid_o    = wr_tag;
  assign bus.m_rready_o  = 1'b1;
  assign bus.s_rvalid_o  = s_rvalid;
  assign bus.s_rdata_o   = data_mem[rd_tag];
  assign bus.s_rid_o     = id_mem[rd_tag];
  assign bus.count_o     = wr_ptr_reg - rd_ptr_reg;
  assign bus.err_unexp_o = err_reg;
endmodule

// File: tb/tb_reorder_buffer_tagged.sv
// Bench for reorder_buffer_tagged: directed scenarios with literal expectations plus randomized
// traffic, all checked every cycle against a queue-based model of outstanding reads.
module tb_reorder_buffer_tagged;
  localparam int DW    = 8;
  localparam int IW    = 4;
  localparam int DEPTH = 16;
  localparam int TW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_tagged_if #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) bus ();

  reorder_buffer_tagged #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Outstanding reads in acceptance order; the head is the next to retire.
  typedef struct {
    int            tag;
    logic [IW-1:0] id;
    bit            have;
    logic [DW-1:0] data;
  } ent_t;

  ent_t q[$];
  int   next_tag = 0;
  bit   exp_err  = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    bus.s_arid_i    = '0;
    bus.s_arvalid_i = 1'b0;
    bus.s_rready_i  = 1'b0;
    bus.m_arready_i = 1'b0;
    bus.m_rdata_i   = '0;
    bus.m_rid_i     = '0;
    bus.m_rvalid_i  = 1'b0;
  endtask

  task automatic check_all();
    bit full;
    bit ev;
    full = (q.size() == DEPTH);
    ev   = (q.size() > 0) && q[0].have;
    chk("s_arready", 32'(bus.s_arready_o), 32'(bus.m_arready_i && !full));
    chk("m_arvalid", 32'(bus.m_arvalid_o), 32'(bus.s_arvalid_i && !full));
    chk("m_arid", 32'(bus.m_arid_o), 32'(next_tag));
    chk("m_rready", 32'(bus.m_rready_o), 32'd1);
    chk("count", 32'(bus.count_o), 32'(q.size()));
    chk("err_unexp", 32'(bus.err_unexp_o), 32'(exp_err));
    chk("s_rvalid", 32'(bus.s_rvalid_o), 32'(ev));
    if (ev) begin
      chk("s_rdata", 32'(bus.s_rdata_o), 32'(q[0].data));
      chk("s_rid", 32'(bus.s_rid_o), 32'(q[0].id));
    end
  endtask

  // Advance the model by one clock edge using the inputs held across that edge.
  task automatic model_update();
    bit full, ar, rs, hit;
    if (rst) begin
      q.delete();
      next_tag = 0;
      exp_err  = 1'b0;
      return;
    end
    full = (q.size() == DEPTH);
    ar   = bus.s_arvalid_i && bus.m_arready_i && !full;
    rs   = (q.size() > 0) && q[0].have && bus.s_rready_i;
    hit  = 1'b0;
    if (bus.m_rvalid_i) begin
      foreach (q[i]) begin
        if (q[i].tag == int'(bus.m_rid_i) && !q[i].have) begin
          q[i].have = 1'b1;
          q[i].data = bus.m_rdata_i;
          hit = 1'b1;
        end
      end
    end
    exp_err = bus.m_rvalid_i && !hit;
    if (rs) begin
      $display("RSP id=%0h data=%02h", q[0].id, q[0].data);
      void'(q.pop_front());
    end
    if (ar) begin
      $display("AR  id=%0h tag=%0d", bus.s_arid_i, next_tag);
      q.push_back('{tag: next_tag, id: bus.s_arid_i, have: 1'b0, data: '0});
      next_tag = (next_tag + 1) % DEPTH;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_ar(input logic [IW-1:0] id);
    bus.s_arvalid_i = 1'b1;
    bus.m_arready_i = 1'b1;
    bus.s_arid_i    = id;
    cycle();
    bus.s_arvalid_i = 1'b0;
  endtask

  task automatic send_r(input int tag, input logic [DW-1:0] data);
    bus.m_rvalid_i = 1'b1;
    bus.m_rid_i    = TW'(tag);
    bus.m_rdata_i  = data;
    cycle();
    bus.m_rvalid_i = 1'b0;
  endtask

  initial begin
    logic [IW-1:0] ids[4];
    int            pick;

    do_reset();
    bus.m_arready_i = 1'b1;
    #1;
    chk("rst_count", 32'(bus.count_o), 32'd0);
    chk("rst_s_rvalid", 32'(bus.s_rvalid_o), 32'd0);
    chk("rst_err", 32'(bus.err_unexp_o), 32'd0);
    chk("rst_arid", 32'(bus.m_arid_o), 32'd0);
    chk("rst_s_arready", 32'(bus.s_arready_o), 32'd1);
    @(negedge clk);

    // In-order responses.
    ids = '{4'd3, 4'd3, 4'd7, 4'd1};
    for (int k = 0; k < 4; k++) begin
      bus.s_arvalid_i = 1'b1;
      bus.m_arready_i = 1'b1;
      bus.s_arid_i    = ids[k];
      #1 chk("t1_arid", 32'(bus.m_arid_o), 32'(k));
      cycle();
    end
    idle();
    #1 chk("t1_count4", 32'(bus.count_o), 32'd4);
    bus.s_rready_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.m_rvalid_i = (k < 4);
      bus.m_rid_i    = TW'(k);
      bus.m_rdata_i  = DW'(8'hA0 + k);
      #1;
      if (k > 0) begin
        chk("t1_rvalid", 32'(bus.s_rvalid_o), 32'd1);
        chk("t1_rid", 32'(bus.s_rid_o), 32'(ids[k-1]));
        chk("t1_rdata", 32'(bus.s_rdata_o), 32'(8'hA0 + k - 1));
      end
      cycle();
    end
    #1 chk("t1_count0", 32'(bus.count_o), 32'd0);

    // Reverse-order responses.
    do_reset();
    ids = '{4'd5, 4'd6, 4'd9, 4'd2};
    for (int k = 0; k < 4; k++) send_ar(ids[k]);
    bus.s_rready_i = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      bus.m_rvalid_i = 1'b1;
      bus.m_rid_i    = TW'(k);
      bus.m_rdata_i  = DW'(8'hB0 + k);
      #1 chk("t2_no_rvalid", 32'(bus.s_rvalid_o), 32'd0);
      cycle();
    end
    bus.m_rvalid_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_rvalid", 32'(bus.s_rvalid_o), 32'd1);
      chk("t2_rid", 32'(bus.s_rid_o), 32'(ids[k]));
      chk("t2_rdata", 32'(bus.s_rdata_o), 32'(8'hB0 + k));
      cycle();
    end
    #1 chk("t2_count0", 32'(bus.count_o), 32'd0);

    // Full, then one retire frees tag 0.
    do_reset();
    for (int k = 0; k < DEPTH; k++) send_ar(IW'(k));
    bus.s_arvalid_i = 1'b1;
    bus.m_arready_i = 1'b1;
    bus.s_arid_i    = 4'hE;
    #1;
    chk("t3_count_full", 32'(bus.count_o), 32'(DEPTH));
    chk("t3_s_arready_full", 32'(bus.s_arready_o), 32'd0);
    chk("t3_m_arvalid_full", 32'(bus.m_arvalid_o), 32'd0);
    bus.m_rvalid_i = 1'b1;
    bus.m_rid_i    = '0;
    bus.m_rdata_i  = 8'h77;
    bus.s_rready_i = 1'b1;
    cycle();
    bus.m_rvalid_i = 1'b0;
    #1;
    chk("t3_retire_rvalid", 32'(bus.s_rvalid_o), 32'd1);
    chk("t3_retire_noar", 32'(bus.s_arready_o), 32'd0);
    cycle();
    bus.s_rready_i = 1'b0;
    #1;
    chk("t3_reuse_ready", 32'(bus.s_arready_o), 32'd1);
    chk("t3_reuse_tag", 32'(bus.m_arid_o), 32'd0);
    chk("t3_count15", 32'(bus.count_o), 32'd15);
    cycle();
    idle();
    #1 chk("t3_count_refull", 32'(bus.count_o), 32'(DEPTH));

    // Stall then drain at one per cycle.
    do_reset();
    ids = '{4'hA, 4'hB, 4'hC, 4'h0};
    for (int k = 0; k < 3; k++) send_ar(ids[k]);
    for (int k = 0; k < 3; k++) send_r(k, DW'(8'h51 + k));
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t4_stall_rvalid", 32'(bus.s_rvalid_o), 32'd1);
      chk("t4_stall_rdata", 32'(bus.s_rdata_o), 32'h51);
      chk("t4_stall_rid", 32'(bus.s_rid_o), 32'hA);
      cycle();
    end
    bus.s_rready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk("t4_drain_count", 32'(bus.count_o), 32'(3 - k));
      if (k < 3) chk("t4_drain_rid", 32'(bus.s_rid_o), 32'(ids[k]));
      cycle();
    end

    // Unexpected beats.
    do_reset();
    send_r(5, 8'hEE);
    #1 chk("t5_err_pulse", 32'(bus.err_unexp_o), 32'd1);
    cycle();
    #1 chk("t5_err_clear", 32'(bus.err_unexp_o), 32'd0);
    send_ar(4'h4);
    send_r(0, 8'h11);
    send_r(0, 8'h22);
    #1;
    chk("t5_dup_err", 32'(bus.err_unexp_o), 32'd1);
    chk("t5_dup_rvalid", 32'(bus.s_rvalid_o), 32'd1);
    chk("t5_dup_data", 32'(bus.s_rdata_o), 32'h11);
    cycle();
    #1 chk("t5_dup_clear", 32'(bus.err_unexp_o), 32'd0);

    // Asynchronous reset with reads outstanding.
    do_reset();
    send_ar(4'h1);
    send_ar(4'h2);
    send_ar(4'h3);
    send_r(0, 8'h44);
    #1;
    chk("t6_pre_rvalid", 32'(bus.s_rvalid_o), 32'd1);
    chk("t6_pre_count", 32'(bus.count_o), 32'd3);
    #1 rst = 1'b1;
    #1;
    chk("t6_rst_rvalid", 32'(bus.s_rvalid_o), 32'd0);
    chk("t6_rst_count", 32'(bus.count_o), 32'd0);
    @(posedge clk);
    model_update();
    @(negedge clk);
    rst = 1'b0;
    bus.s_arvalid_i = 1'b1;
    bus.m_arready_i = 1'b1;
    bus.s_arid_i    = 4'h9;
    #1 chk("t6_tag0", 32'(bus.m_arid_o), 32'd0);
    cycle();
    idle();
    send_r(1, 8'h55);
    #1 chk("t6_stale_err", 32'(bus.err_unexp_o), 32'd1);
    cycle();

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bus.s_arvalid_i = ($urandom_range(0, 2) != 0);
      bus.s_arid_i    = IW'($urandom);
      bus.m_arready_i = ($urandom_range(0, 3) != 0);
      bus.s_rready_i  = ($urandom_range(0, 2) != 0);
      bus.m_rvalid_i  = ($urandom_range(0, 1) != 0);
      bus.m_rdata_i   = DW'($urandom);
      if (q.size() > 0 && $urandom_range(0, 7) != 0) begin
        pick = int'($urandom_range(0, q.size() - 1));
        bus.m_rid_i = TW'(q[pick].tag);
      end else begin
        bus.m_rid_i = TW'($urandom);
      end
      cycle();
    end

    idle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
